fetch_pc_ctrl: RTL

Fetch-stage program-counter sequencer for the RV64I/Zba pipeline. It owns the PC register and decides each cycle whether the PC holds, advances by 4, or redirects. Inputs are the hazard unit's stall, the instruction memory's ready, and execute-stage branch/jump redirects. A redirect that arrives while fetch cannot advance is buffered, and wrong-path fetch valid is suppressed until it is taken. The block sits between the hazard unit / EX stage and the instruction-memory request port.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_pc_ctrl_if.sv | 22 ++
 rtl/fetch_pc_ctrl_pcreg.sv | 20 ++
 rtl/fetch_pc_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;

   // A target is a fault only when checking is enabled and it is not word aligned.
   function automatic logic misaligned(input logic [63:0] target, input logic check);
      return check && (target[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Hazard/EX control inputs and instruction-memory request outputs of the fetch PC sequencer.
interface fetch_pc_ctrl_if;
   logic        StallF;
   logic        ImemReady;
   logic        RedirectE;
   logic [63:0] PCTargetE;
   logic [63:0] PC;
   logic [63:0] PCPlus4F;
   logic        FetchValidF;
   logic        FlushD;
   logic        MisalignedF;

   modport master (
      input  StallF, ImemReady, RedirectE, PCTargetE,
      output PC, PCPlus4F, FetchValidF, FlushD, MisalignedF
   );

   modport slave (
      output StallF, ImemReady, RedirectE, PCTargetE,
      input  PC, PCPlus4F, FetchValidF, FlushD, MisalignedF
   );
endinterface

// File: rtl/fetch_pc_ctrl_pcreg.sv
// Program-counter flop with a configurable reset value.
module fetch_pc_ctrl_pcreg #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] PCNext,
   output logic [63:0] PC
);

   logic [63:0] pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= PCNext;
   end

   assign PC = pc_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: hold / advance / redirect, with buffered redirects and a
// sticky misalignment halt.
module fetch_pc_ctrl
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input logic             clk,
   input logic             rst,
   fetch_pc_ctrl_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [63:0]  pend_q, pend_d;
   logic         mis_q, mis_d;
   logic [63:0]  pc, pc_next, pc_plus4;
   logic         advance, redir_bad;
   logic         fetch_valid, flush;

   assign advance   = !bus.StallF && bus.ImemReady;
   assign redir_bad = bus.RedirectE && misaligned(bus.PCTargetE, ALIGN_CHECK);
   assign pc_plus4  = pc + 64'(INSTR_BYTES);

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      mis_d       = mis_q;
      pc_next     = pc;
      fetch_valid = 1'b0;
      flush       = 1'b0;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            fetch_valid = !bus.RedirectE;
            if (redir_bad) begin
               flush   = 1'b1;
               pc_next = bus.PCTargetE;
               mis_d   = 1'b1;
               state_d = HALT;
            end else if (bus.RedirectE) begin
               flush = 1'b1;
               if (advance) begin
                  pc_next = bus.PCTargetE;
               end else begin
                  pend_d  = bus.PCTargetE;
                  state_d = PEND;
               end
            end else if (advance) begin
               pc_next = pc_plus4;
            end
         end
         PEND: begin
            // The current PC is wrong-path until the buffered target is loaded.
            flush = 1'b1;
            if (redir_bad) begin
               pc_next = bus.PCTargetE;
               mis_d   = 1'b1;
               state_d = HALT;
            end else if (advance) begin
               pc_next = bus.RedirectE ? bus.PCTargetE : pend_q;
               state_d = RUN;
            end else if (bus.RedirectE) begin
               pend_d = bus.PCTargetE;
            end
         end
         HALT: flush = 1'b1;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pend_q  <= 64'h0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
      end
   end

   fetch_pc_ctrl_pcreg #(
      .RESET_PC (RESET_PC)
   ) u_pcreg (
      .clk    (clk),
      .rst    (rst),
      .PCNext (pc_next),
      .PC     (pc)
   );

   assign bus.PC          = pc;
   assign bus.PCPlus4F    = pc_plus4;
   assign bus.FetchValidF = fetch_valid;
   assign bus.FlushD      = flush;
   assign bus.MisalignedF = mis_q;

endmodule
